// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt / status front end:
//   - NUM_IRQ, IRQ_ID_W : interrupt line count and index width
//   - STATUS_W and the bit positions inside the status_flags bundle
//   - irq_state_e       : request/acknowledge FSM states
//   - alu_flags_t       : captured ALU condition flags
//   - calc_alu_flags()  : derives the flag set from an ALU result
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_IRQ  = 8;
    localparam int IRQ_ID_W = 3;
    localparam int STATUS_W = 16;

    // status_flags layout: {eligible[7:0], int_en, 2'b00, zero, carry, neg, parity[1:0]}
    localparam int SF_ELIG_LSB = 8;
    localparam int SF_INT_EN   = 7;
    localparam int SF_ZERO     = 4;
    localparam int SF_CARRY    = 3;
    localparam int SF_NEG      = 2;
    localparam int SF_PAR_HI   = 1;
    localparam int SF_PAR_LO   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    typedef struct packed {
        logic       zero;
        logic       carry;
        logic       neg;
        logic [1:0] parity;   // {^upper half, ^lower half}
    } alu_flags_t;

    function automatic alu_flags_t calc_alu_flags(input logic [31:0] result,
                                                  input logic        carry);
        alu_flags_t f;
        f.zero      = (result == 32'd0);
        f.carry     = carry;
        f.neg       = result[31];
        f.parity[1] = ^result[31:16];
        f.parity[0] = ^result[15:0];
        return f;
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// ---------------------------------------------------------------------------
// irq_prio_pick
// Fixed-priority picker: returns the index of the highest set bit of a
// NUM_IRQ-wide vector plus a flag telling whether any bit is set.
// Ports:
//   vec_i  in  NUM_IRQ   candidate vector
//   idx_o  out IRQ_ID_W  highest set index (0 when vec_i is zero)
//   any_o  out 1         |vec_i
// ---------------------------------------------------------------------------
module irq_prio_pick
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0]  vec_i,
    output logic [IRQ_ID_W-1:0] idx_o,
    output logic                any_o
);

    // Scanning upward lets later (higher) set bits overwrite earlier ones,
    // so the highest index wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IRQ_ID_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/irq_status_ctrl.sv
// ---------------------------------------------------------------------------
// irq_status_ctrl
// Edge-detects and latches 8 interrupt lines, masks them, captures ALU
// condition flags and runs a request/acknowledge handshake toward the core
// with an acknowledge timeout.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   irq_in[7:0]   interrupt lines, rising edge = request
//   mask_wr/mask_data[7:0]   mask load (1 = line enabled)
//   int_en_set/int_en_clr    global enable control (clear wins)
//   alu_valid/alu_result[31:0]/alu_carry   ALU flag capture
//   irq_ack       core accepts current request
//   irq_req       request pending toward core (registered)
//   irq_id[2:0]   index of requested line, stable while irq_req=1
//   status_flags[15:0]  {eligible, int_en, 2'b00, zero, carry, neg, parity}
//   timeout_err   one-cycle pulse when a request is abandoned
// ---------------------------------------------------------------------------
module irq_status_ctrl
    import irq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_wr,
    input  logic [NUM_IRQ-1:0]  mask_data,
    input  logic                int_en_set,
    input  logic                int_en_clr,
    input  logic                alu_valid,
    input  logic [31:0]         alu_result,
    input  logic                alu_carry,
    input  logic                irq_ack,
    output logic                irq_req,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [STATUS_W-1:0] status_flags,
    output logic                timeout_err
);

    localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    // ---------------- registers ----------------
    logic [NUM_IRQ-1:0]  irq_prev_q;
    logic [NUM_IRQ-1:0]  pending_q,  pending_d;
    logic [NUM_IRQ-1:0]  irq_mask_q, irq_mask_d;
    logic                int_en_q,   int_en_d;
    alu_flags_t          alu_flags_q, alu_flags_d;
    irq_state_e          state_q,    state_d;
    logic                irq_req_q,  irq_req_d;
    logic [IRQ_ID_W-1:0] irq_id_q,   irq_id_d;
    logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
    logic                timeout_err_q, timeout_err_d;

    // ---------------- combinational helpers ----------------
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  clr;
    logic [NUM_IRQ-1:0]  eligible;
    logic [IRQ_ID_W-1:0] pick_id;
    logic                pick_any;
    logic                ack_take;

    assign rise     = irq_in & ~irq_prev_q;
    assign eligible = pending_q & irq_mask_q;

    // An acknowledge only counts while the request is actually visible to
    // the core; acks in other states (or on the silent first REQ cycle)
    // are ignored.
    assign ack_take = (state_q == REQ) && irq_req_q && irq_ack;

    // Per-line pending update: a rise in the same cycle as the clear keeps
    // the bit set, so a back-to-back edge on the served line is not lost.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
        assign clr[gi]       = ack_take && (irq_id_q == IRQ_ID_W'(gi));
        assign pending_d[gi] = (pending_q[gi] & ~clr[gi]) | rise[gi];
    end

    irq_prio_pick u_pick (
        .vec_i (eligible),
        .idx_o (pick_id),
        .any_o (pick_any)
    );

    // ---------------- mask / enable / ALU flags ----------------
    always_comb begin
        irq_mask_d  = mask_wr ? mask_data : irq_mask_q;
        int_en_d    = int_en_q;
        if (int_en_clr) begin
            int_en_d = 1'b0;
        end else if (int_en_set) begin
            int_en_d = 1'b1;
        end
        alu_flags_d = alu_valid ? calc_alu_flags(alu_result, alu_carry) : alu_flags_q;
    end

    // ---------------- handshake FSM ----------------
    always_comb begin
        state_d       = state_q;
        irq_id_d      = irq_id_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (int_en_q && pick_any) begin
                    state_d   = REQ;
                    irq_id_d  = pick_id;
                    tmo_cnt_d = '0;
                end
            end
            REQ: begin
                // Priority: acknowledge, then enable drop, then timeout.
                if (ack_take) begin
                    state_d = GAP;
                end else if (!int_en_q) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // irq_req rises one cycle after REQ is entered and falls on the
        // same edge that leaves REQ.
        irq_req_d = (state_q == REQ) && (state_d == REQ);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q    <= '0;
            pending_q     <= '0;
            irq_mask_q    <= '0;
            int_en_q      <= 1'b0;
            alu_flags_q   <= '0;
            state_q       <= IDLE;
            irq_req_q     <= 1'b0;
            irq_id_q      <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            irq_prev_q    <= irq_in;
            pending_q     <= pending_d;
            irq_mask_q    <= irq_mask_d;
            int_en_q      <= int_en_d;
            alu_flags_q   <= alu_flags_d;
            state_q       <= state_d;
            irq_req_q     <= irq_req_d;
            irq_id_q      <= irq_id_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ---------------- outputs ----------------
    assign irq_req     = irq_req_q;
    assign irq_id      = irq_id_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        status_flags = '0;
        status_flags[SF_ELIG_LSB +: NUM_IRQ] = eligible;
        status_flags[SF_INT_EN]              = int_en_q;
        status_flags[SF_ZERO]                = alu_flags_q.zero;
        status_flags[SF_CARRY]               = alu_flags_q.carry;
        status_flags[SF_NEG]                 = alu_flags_q.neg;
        status_flags[SF_PAR_HI]              = alu_flags_q.parity[1];
        status_flags[SF_PAR_LO]              = alu_flags_q.parity[0];
    end

endmodule

// File: tb/tb_irq_status_ctrl.sv
module tb_irq_status_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        mask_wr;
    logic [7:0]  mask_data;
    logic        int_en_set;
    logic        int_en_clr;
    logic        alu_valid;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        irq_ack;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic [15:0] status_flags;
    logic        timeout_err;

    irq_status_ctrl #(.ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .int_en_set   (int_en_set),
        .int_en_clr   (int_en_clr),
        .alu_valid    (alu_valid),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .irq_ack      (irq_ack),
        .irq_req      (irq_req),
        .irq_id       (irq_id),
        .status_flags (status_flags),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Number of posedges seen so far; read at negedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int at;   // expected negedge cycle of irq_req rising, -1 = any
    } req_exp_t;

    req_exp_t req_q[$];
    int       tmo_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic req_prev = 1'b0;
    always @(negedge clk) begin : mon
        req_exp_t e;
        int t;
        if (irq_req && !req_prev) begin
            if (req_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_req: got irq_id=%0d at cycle %0d, required no request", irq_id, cyc);
            end else begin
                e = req_q.pop_front();
                $display("[TB] request irq_id=%0d at cycle %0d", irq_id, cyc);
                check("req_id", irq_id, e.id);
                if (e.at >= 0) check("req_cycle", cyc, e.at);
            end
        end
        if (timeout_err) begin
            if (tmo_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_timeout: got timeout_err=1 at cycle %0d, required 0", cyc);
            end else begin
                t = tmo_q.pop_front();
                $display("[TB] timeout_err at cycle %0d", cyc);
                check("timeout_cycle", cyc, t);
            end
        end
        req_prev <= irq_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!irq_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!irq_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got irq_req=0 after 50 cycles, required 1", name);
        end
    endtask

    task automatic pulse(input logic [7:0] m, output int c);
        c = cyc;
        irq_in = irq_in | m;
        @(negedge clk);
        irq_in = irq_in & ~m;
    endtask

    task automatic ack_now(output int c);
        c = cyc;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    initial begin : stim
        int c;
        int a;
        rst = 1'b1; irq_in = '0; mask_wr = 0; mask_data = '0;
        int_en_set = 0; int_en_clr = 0; alu_valid = 0; alu_result = '0;
        alu_carry = 0; irq_ack = 0;

        cycles(2);
        check("rst_status", status_flags, 16'h0000);
        check("rst_req", irq_req, 1'b0);
        check("rst_id", irq_id, 3'd0);
        check("rst_tmo", timeout_err, 1'b0);
        rst = 1'b0;

        mask_wr = 1; mask_data = 8'hFF; int_en_set = 1;
        cycles(1);
        mask_wr = 0; int_en_set = 0;
        check("int_en_on", status_flags[7], 1'b1);

        // 1: single line, exact latency, ack and GAP
        pulse(8'h04, c);
        req_q.push_back('{2, c + 3});
        check("t1_elig", status_flags[15:8], 8'h04);
        wait_req("t1_wait");
        ack_now(a);
        check("t1_req_drop", irq_req, 1'b0);
        check("t1_bit10", status_flags[10], 1'b0);
        cycles(3);
        check("t1_idle_req", irq_req, 1'b0);

        // 2: simultaneous rises, highest first, GAP before the second
        pulse(8'h42, c);
        req_q.push_back('{6, c + 3});
        check("t2_elig", status_flags[15:8], 8'h42);
        wait_req("t2_wait_a");
        ack_now(a);
        req_q.push_back('{1, a + 4});
        wait_req("t2_wait_b");
        ack_now(a);
        cycles(2);
        check("t2_empty", status_flags[15:8], 8'h00);

        // 3: masked line latches but is not eligible until mask opens
        mask_wr = 1; mask_data = 8'h01;
        cycles(1);
        mask_wr = 0;
        pulse(8'h20, c);
        cycles(3);
        check("t3_masked", status_flags[15:8], 8'h00);
        check("t3_noreq", irq_req, 1'b0);
        c = cyc;
        mask_wr = 1; mask_data = 8'hFF;
        cycles(1);
        mask_wr = 0;
        req_q.push_back('{5, c + 3});
        check("t3_unmasked", status_flags[15:8], 8'h20);
        wait_req("t3_wait");
        ack_now(a);
        cycles(2);

        // 4: ack timeout, pending kept, request re-issued
        pulse(8'h08, c);
        req_q.push_back('{3, c + 3});
        req_q.push_back('{3, c + 20});
        tmo_q.push_back(c + 18);
        cycles(c + 18 - cyc);
        check("t4_tmo_pulse", timeout_err, 1'b1);
        check("t4_pending", status_flags[11], 1'b1);
        check("t4_req_low", irq_req, 1'b0);
        cycles(1);
        check("t4_tmo_1cyc", timeout_err, 1'b0);
        wait_req("t4_wait");
        ack_now(a);
        cycles(2);

        // 7: rise on the served line during its ack keeps it pending
        pulse(8'h10, c);
        req_q.push_back('{4, c + 3});
        wait_req("t7_wait_a");
        a = cyc;
        irq_ack = 1; irq_in[4] = 1'b1;
        cycles(1);
        irq_ack = 0; irq_in[4] = 1'b0;
        req_q.push_back('{4, a + 4});
        check("t7_kept", status_flags[12], 1'b1);
        wait_req("t7_wait_b");
        ack_now(a);
        cycles(2);
        check("t7_empty", status_flags[15:8], 8'h00);

        // 5: ALU flag capture and hold
        alu_valid = 1; alu_result = 32'h0; alu_carry = 1;
        cycles(1);
        check("t5_zero", status_flags[4:0], 5'b11000);
        alu_result = 32'h8000_0001; alu_carry = 0;
        cycles(1);
        alu_valid = 0;
        check("t5_neg_par", status_flags[4:0], 5'b00111);
        alu_result = 32'h0; alu_carry = 1;
        cycles(1);
        check("t5_hold", status_flags[4:0], 5'b00111);

        // enable set and clear together -> disabled
        int_en_set = 1; int_en_clr = 1;
        cycles(1);
        int_en_set = 0; int_en_clr = 0;
        check("en_clr_wins", status_flags[7], 1'b0);
        pulse(8'h01, c);
        cycles(3);
        check("en_off_pend", status_flags[8], 1'b1);
        check("en_off_noreq", irq_req, 1'b0);
        c = cyc;
        int_en_set = 1;
        cycles(1);
        int_en_set = 0;
        req_q.push_back('{0, c + 3});
        wait_req("en_on_wait");

        // 6: reset during a live request, line held high across release
        rst = 1; irq_in = 8'h80;
        cycles(1);
        check("t6_req", irq_req, 1'b0);
        check("t6_status", status_flags, 16'h0000);
        check("t6_tmo", timeout_err, 1'b0);
        rst = 0; mask_wr = 1; mask_data = 8'hFF;
        cycles(1);
        mask_wr = 0;
        check("t6_high_at_rel", status_flags[15:8], 8'h80);
        irq_in = 8'h00;
        cycles(3);

        check("req_queue_left", req_q.size(), 0);
        check("tmo_queue_left", tmo_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
